// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion: one schedule word per cycle,
// grouped into 128-bit round keys delivered 0..Nr on a valid/ready stream.
module aes_key_schedule #(
    parameter int MAX_KEY_BITS = 256,
    parameter int SBOX_REG     = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         start_err,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_index,
    output logic [127:0] rk_out,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, LOAD, GEN, DRAIN} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte x lives at the (255-x)th byte from the LSB end, i.e. offset ~x.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] pos;
        pos = {~x, 3'b000};
        return SBOX[pos +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t        state;
    logic [255:0]  key_q;
    logic [2:0]    nk_m1;
    logic [5:0]    last_idx;
    logic [5:0]    cnt;
    logic [2:0]    mod_cnt;
    logic [7:0]    rcon;
    logic [31:0]   win [0:7];
    logic [31:0]   asm_buf [0:2];
    logic [31:0]   sub_q;
    logic          sub_vld;

    logic          key_ok;
    logic [2:0]    new_nk_m1;
    logic [5:0]    new_last;
    logic [255:0]  key_sh;
    logic          is_rot;
    logic          need_sub;
    logic [31:0]   sub_in;
    logic [31:0]   sub_res;
    logic [31:0]   temp;
    logic [31:0]   new_word;
    logic          sub_ok;
    logic          accept;
    logic          adv;

    // Decode the requested key length against the widest supported key.
    always_comb begin
        key_ok    = 1'b0;
        new_nk_m1 = 3'd3;
        new_last  = 6'd43;
        case (key_len)
            2'b00: begin key_ok = (MAX_KEY_BITS >= 128); new_nk_m1 = 3'd3; new_last = 6'd43; end
            2'b01: begin key_ok = (MAX_KEY_BITS >= 192); new_nk_m1 = 3'd5; new_last = 6'd51; end
            2'b10: begin key_ok = (MAX_KEY_BITS >= 256); new_nk_m1 = 3'd7; new_last = 6'd59; end
            default: key_ok = 1'b0;
        endcase
    end

    // Next schedule word and the handshake that decides whether it is produced this cycle.
    always_comb begin
        key_sh   = key_q << {cnt[2:0], 5'b00000};
        is_rot   = (mod_cnt == 3'd0);
        need_sub = (state == GEN) && (is_rot || (nk_m1 == 3'd7 && mod_cnt == 3'd4));
        sub_in   = is_rot ? rot_word(win[0]) : win[0];
        sub_res  = (SBOX_REG != 0) ? sub_q : sub_word(sub_in);
        temp     = win[0];
        if (need_sub) temp = is_rot ? (sub_res ^ {rcon, 24'h0}) : sub_res;
        new_word = (state == LOAD) ? key_sh[255:224] : (win[nk_m1] ^ temp);
        sub_ok   = (SBOX_REG == 0) || !need_sub || sub_vld;
        accept   = rk_valid && rk_ready;
        // The 4th word of a group may only land when the output register can take it.
        adv      = (state == LOAD || state == GEN) && sub_ok &&
                   (cnt[1:0] != 2'd3 || !rk_valid || rk_ready);
    end

    // Job FSM, word window, round-key assembly and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            start_err <= 1'b0;
            rk_valid  <= 1'b0;
            rk_index  <= 4'd0;
            rk_out    <= 128'd0;
            done      <= 1'b0;
            key_q     <= 256'd0;
            nk_m1     <= 3'd3;
            last_idx  <= 6'd43;
            cnt       <= 6'd0;
            mod_cnt   <= 3'd0;
            rcon      <= 8'h01;
            sub_q     <= 32'd0;
            sub_vld   <= 1'b0;
            for (int k = 0; k < 8; k++) win[k] <= 32'd0;
            for (int k = 0; k < 3; k++) asm_buf[k] <= 32'd0;
        end else begin
            start_err <= 1'b0;
            done      <= 1'b0;
            if (adv) begin
                sub_vld <= 1'b0;
            end else if (SBOX_REG != 0 && need_sub && !sub_vld) begin
                sub_q   <= sub_word(sub_in);
                sub_vld <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (key_ok) begin
                            key_q    <= key_in;
                            nk_m1    <= new_nk_m1;
                            last_idx <= new_last;
                            cnt      <= 6'd0;
                            mod_cnt  <= 3'd0;
                            rcon     <= 8'h01;
                            sub_vld  <= 1'b0;
                            busy     <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            start_err <= 1'b1;
                        end
                    end
                end
                LOAD, GEN: begin
                    if (adv) begin
                        for (int k = 7; k > 0; k--) win[k] <= win[k-1];
                        win[0]  <= new_word;
                        cnt     <= cnt + 6'd1;
                        mod_cnt <= (mod_cnt == nk_m1) ? 3'd0 : mod_cnt + 3'd1;
                        if (state == GEN && is_rot) rcon <= xtime(rcon);
                        if (cnt[1:0] == 2'd3) begin
                            rk_out   <= {asm_buf[0], asm_buf[1], asm_buf[2], new_word};
                            rk_index <= cnt[5:2];
                            rk_valid <= 1'b1;
                        end else begin
                            asm_buf[cnt[1:0]] <= new_word;
                            if (accept) rk_valid <= 1'b0;
                        end
                        if (state == LOAD && cnt[2:0] == nk_m1) state <= GEN;
                        if (cnt == last_idx) state <= DRAIN;
                    end else if (accept) begin
                        rk_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        rk_valid <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
